// File: rtl/bm_param_grad_acc.sv
// Multi-tile norm-parameter gradient accumulator: per-column gradb/gradg reduction across tiles.
// Optional saturation of the final outputs and a sticky sat_flag port: define BM_PARAM_SAT_EN.
module bm_param_grad_acc #(
  parameter int bitwidth      = 16,
  parameter int tile_len      = 2,
  parameter int hidden_dim    = 8,
  parameter int num_tiles     = 4,
  parameter int frac_bits     = 8,
  parameter int addr_bitwidth = $clog2(hidden_dim),
  parameter int acc_bitwidth  = 2*bitwidth + $clog2(tile_len*num_tiles),
  parameter int tile_bitwidth = (num_tiles > 1) ? $clog2(num_tiles) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         clear,
  input  logic [tile_len*bitwidth-1:0] gradz,
  input  logic [tile_len*bitwidth-1:0] y1,
  output logic [addr_bitwidth-1:0]     addr,
  output logic                         busy,
  output logic                         done,
  output logic [tile_bitwidth-1:0]     tile_idx,
  output logic [bitwidth-1:0]          gradg_out,
  output logic [bitwidth-1:0]          gradb_out,
  output logic                         gradg_out_valid,
  output logic                         gradb_out_valid,
  output logic                         gradg_out_last,
  output logic                         gradb_out_last
`ifdef BM_PARAM_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  localparam logic [addr_bitwidth-1:0] LAST_COL  = addr_bitwidth'(hidden_dim - 1);
  localparam logic [tile_bitwidth-1:0] LAST_TILE = tile_bitwidth'(num_tiles - 1);

  state_t r_state;
  state_t w_next;

  logic [addr_bitwidth-1:0] r_col;
  logic [tile_bitwidth-1:0] r_tile;

  // Read-return, operand, sum and accumulate stages
  logic                            r_rd_vld;
  logic [addr_bitwidth-1:0]        r_rd_col;
  logic                            r_s1_vld;
  logic [addr_bitwidth-1:0]        r_s1_col;
  logic [tile_len*bitwidth-1:0]    r_s1_gz;
  logic [tile_len*bitwidth-1:0]    r_s1_y1;
  logic                            r_s2_vld;
  logic [addr_bitwidth-1:0]        r_s2_col;
  logic signed [acc_bitwidth-1:0]  r_s2_sb;
  logic signed [acc_bitwidth-1:0]  r_s2_sg;

  logic signed [acc_bitwidth-1:0]  r_accb [hidden_dim];
  logic signed [acc_bitwidth-1:0]  r_accg [hidden_dim];

  logic                            r_done;
  logic                            r_ovld;
  logic                            r_olast;
  logic [bitwidth-1:0]             r_gb;
  logic [bitwidth-1:0]             r_gg;

  logic signed [acc_bitwidth-1:0]  w_row_b [tile_len];
  logic signed [acc_bitwidth-1:0]  w_row_g [tile_len];
  logic signed [acc_bitwidth-1:0]  w_sb;
  logic signed [acc_bitwidth-1:0]  w_sg;
  logic signed [acc_bitwidth-1:0]  w_sumb;
  logic signed [acc_bitwidth-1:0]  w_sumg;
  logic                            w_first_tile;
  logic                            w_last_tile;
  logic                            w_idle_clear;

`ifdef BM_PARAM_SAT_EN
  localparam logic signed [acc_bitwidth-1:0] SAT_MAX =
    {{(acc_bitwidth-bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
  localparam logic signed [acc_bitwidth-1:0] SAT_MIN =
    {{(acc_bitwidth-bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};

  function automatic logic clamped(input logic signed [acc_bitwidth-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction
`endif

  function automatic logic [bitwidth-1:0] reduce(input logic signed [acc_bitwidth-1:0] v);
`ifdef BM_PARAM_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[bitwidth-1:0];
    if (v < SAT_MIN) return SAT_MIN[bitwidth-1:0];
    return v[bitwidth-1:0];
`else
    return v[bitwidth-1:0];
`endif
  endfunction

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_next = S_SWEEP;
      S_SWEEP: if (r_col == LAST_COL) w_next = S_DRAIN;
      S_DRAIN: if (r_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy         = (r_state != S_IDLE);
  assign addr         = (r_state == S_SWEEP) ? r_col : '0;
  assign w_idle_clear = (r_state == S_IDLE) && clear;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                        r_col <= '0;
    else if (r_state == S_SWEEP && r_col != LAST_COL) r_col <= r_col + 1'b1;
    else                                              r_col <= '0;
  end

  // The tile index is stable for a whole tile; it advances as the tile retires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             r_tile <= '0;
    else if (w_idle_clear) r_tile <= '0;
    else if (r_done)       r_tile <= (r_tile == LAST_TILE) ? '0 : r_tile + 1'b1;
  end

  assign tile_idx     = r_tile;
  assign w_first_tile = (r_tile == '0);
  assign w_last_tile  = (r_tile == LAST_TILE);

  // ---------------------------------------------------------------- datapath
  for (genvar r = 0; r < tile_len; r++) begin : g_row
    logic signed [bitwidth-1:0]   w_gz;
    logic signed [bitwidth-1:0]   w_y;
    logic signed [2*bitwidth-1:0] w_prod;
    logic signed [2*bitwidth-1:0] w_shift;
    assign w_gz       = r_s1_gz[r*bitwidth +: bitwidth];
    assign w_y        = r_s1_y1[r*bitwidth +: bitwidth];
    assign w_prod     = w_gz * w_y;
    assign w_shift    = w_prod >>> frac_bits;
    assign w_row_b[r] = acc_bitwidth'(w_gz);
    assign w_row_g[r] = acc_bitwidth'(w_shift);
  end

  always_comb begin
    w_sb = '0;
    w_sg = '0;
    for (int r = 0; r < tile_len; r++) begin
      w_sb = w_sb + w_row_b[r];
      w_sg = w_sg + w_row_g[r];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_vld <= 1'b0;
      r_rd_col <= '0;
      r_s1_vld <= 1'b0;
      r_s1_col <= '0;
      r_s1_gz  <= '0;
      r_s1_y1  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_col <= '0;
      r_s2_sb  <= '0;
      r_s2_sg  <= '0;
    end else begin
      r_rd_vld <= (r_state == S_SWEEP);
      r_rd_col <= r_col;
      r_s1_vld <= r_rd_vld;
      r_s1_col <= r_rd_col;
      if (r_rd_vld) begin
        r_s1_gz <= gradz;
        r_s1_y1 <= y1;
      end
      r_s2_vld <= r_s1_vld;
      r_s2_col <= r_s1_col;
      if (r_s1_vld) begin
        r_s2_sb <= w_sb;
        r_s2_sg <= w_sg;
      end
    end
  end

  // Tile 0 overwrites, later tiles add into the stored partial sums.
  assign w_sumb = w_first_tile ? r_s2_sb : r_accb[r_s2_col] + r_s2_sb;
  assign w_sumg = w_first_tile ? r_s2_sg : r_accg[r_s2_col] + r_s2_sg;

  // NOTE: the accumulator bank has no reset; tile 0 writes every entry before any later tile reads it.
  always_ff @(posedge clk) begin
    if (r_s2_vld) begin
      r_accb[r_s2_col] <= w_sumb;
      r_accg[r_s2_col] <= w_sumg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done  <= 1'b0;
      r_ovld  <= 1'b0;
      r_olast <= 1'b0;
      r_gb    <= '0;
      r_gg    <= '0;
    end else begin
      r_done  <= r_s2_vld && (r_s2_col == LAST_COL);
      r_ovld  <= r_s2_vld && w_last_tile;
      r_olast <= r_s2_vld && w_last_tile && (r_s2_col == LAST_COL);
      if (r_s2_vld && w_last_tile) begin
        r_gb <= reduce(w_sumb);
        r_gg <= reduce(w_sumg);
      end
    end
  end

  assign done            = r_done;
  assign gradb_out       = r_gb;
  assign gradg_out       = r_gg;
  assign gradb_out_valid = r_ovld;
  assign gradg_out_valid = r_ovld;
  assign gradb_out_last  = r_olast;
  assign gradg_out_last  = r_olast;

`ifdef BM_PARAM_SAT_EN
  logic r_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             r_sat <= 1'b0;
    else if (w_idle_clear) r_sat <= 1'b0;
    else if (r_s2_vld && w_last_tile && (clamped(w_sumb) || clamped(w_sumg)))
      r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`endif

endmodule
